inflate_out_packer: RTL

- Downstream stage of the inflate decoder core. Consumes its 8-bit output byte stream (valid/ready) and packs byte pairs into 16-bit words for the 16-bit output FIFO.
- At end of stream, emits a trailing odd byte as a padded word and raises a drained/done indication usable as the decode_finish interrupt source.
- Clears on flush (DMA stop).

---
 rtl/inflate_pkg.sv | 17 +
 rtl/inflate_out_packer_if.sv | 17 +
 rtl/inflate_out_packer.sv | 98 +++++++++
 3 files changed

// File: rtl/inflate_pkg.sv
// Shared definitions for the inflate byte/word stream path: widths and packer
// FSM state encoding.
package inflate_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // First byte of a pair lands in the low half of the word.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/inflate_out_packer_if.sv
// Byte-in / word-out stream bundle of the inflate output packer.
// slave = packer side, master = byte source plus word sink.
interface inflate_out_packer_if;
  import inflate_pkg::*;
  logic [BYTE_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [WORD_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              out_odd;

  modport slave  (input in_data, in_vld, out_rdy,
                  output in_rdy, out_data, out_vld, out_odd);
  modport master (output in_data, in_vld, out_rdy,
                  input in_rdy, out_data, out_vld, out_odd);
endinterface

// File: rtl/inflate_out_packer.sv
// Packs inflate output bytes into 16-bit FIFO words, pads a trailing odd byte
// and reports done once drained. Optional counter: INFLATE_PACK_CNT_EN.
module inflate_out_packer
  import inflate_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00,
  parameter int                CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             finish,
  inflate_out_packer_if.slave bus,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             done
);
  logic [1:0]        r_state;
  logic [BYTE_W-1:0] r_lo;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_vld;
  logic              r_out_odd;
  logic              w_slot_free;
  logic              w_in_rdy;
  logic              w_byte;

  // Output register can take a new word this cycle (empty or draining).
  assign w_slot_free = !r_out_vld | bus.out_rdy;

  always_comb begin
    w_in_rdy = 1'b0;
    case (r_state)
      S_EMPTY: w_in_rdy = 1'b1;
      S_HALF:  w_in_rdy = w_slot_free;
      default: w_in_rdy = 1'b0;
    endcase
    if (rst || flush) w_in_rdy = 1'b0;
  end

  assign w_byte       = bus.in_vld & w_in_rdy;
  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_data = r_out_data;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_odd  = r_out_odd;
  assign done         = (r_state == S_DONE) & !r_out_vld;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= S_EMPTY;
      r_lo       <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_out_odd  <= 1'b0;
    end else begin
      if (r_out_vld && bus.out_rdy) r_out_vld <= 1'b0;
      // A byte accepted alongside finish is folded in before finish is acted on.
      case (r_state)
        S_EMPTY: begin
          if (w_byte) begin
            r_lo    <= bus.in_data;
            r_state <= finish ? S_TAIL : S_HALF;
          end else if (finish) begin
            r_state <= S_DONE;
          end
        end
        S_HALF: begin
          if (w_byte) begin
            r_out_data <= pack_word(bus.in_data, r_lo);
            r_out_odd  <= 1'b0;
            r_out_vld  <= 1'b1;
            r_state    <= finish ? S_DONE : S_EMPTY;
          end else if (finish) begin
            r_state <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (w_slot_free) begin
            r_out_data <= pack_word(PAD_BYTE, r_lo);
            r_out_odd  <= 1'b1;
            r_out_vld  <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INFLATE_PACK_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || flush) r_cnt <= '0;
    else if (w_byte)  r_cnt <= r_cnt + 1'b1;
  end
  assign byte_cnt = r_cnt;
`else
  assign byte_cnt = '0;
`endif
endmodule
